// File: rtl/aes_sbox_dom_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the masked SubBytes array.
package aes_sbox_dom_pkg;

  localparam logic [7:0] AFFINE_C = 8'h63;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  // Four DOM multiplications per S-box, 8 bits per share pair each.
  function automatic int z_width(input int shares);
    return 16 * shares * (shares - 1);
  endfunction

  // Output blinding: one fresh byte per non-zero share.
  function automatic int b_width(input int shares);
    return 8 * (shares - 1);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bit offset of byte b, share s in the flat state vector.
  function automatic int share_lsb(input int b, input int s, input int shares);
    return (b * shares + s) * 8;
  endfunction

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Linear part of the AES affine map (no constant).
  function automatic logic [7:0] affine_lin(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
  endfunction

endpackage

// File: rtl/aes_sbox_dom_core.sv
// Pipelined DOM S-box: shared inversion as x^254 (four DOM multiplies), then affine + blinding.
// Stage map: s1 x^3, s2 x^15, s3 x^252, s4 x^254, s5 affine/blind, extra stages are plain delay.
// SBOX_LATENCY must be at least 5.
module aes_sbox_dom_core
  import aes_sbox_dom_pkg::*;
#(
  parameter  int SHARES       = 2,
  parameter  int SBOX_LATENCY = 5,
  localparam int ZW           = z_width(SHARES),
  localparam int BW           = b_width(SHARES)
) (
  input  logic                   clk,
  input  logic [SHARES-1:0][7:0] x,
  input  logic [ZW-1:0]          z,
  input  logic [BW-1:0]          b,
  output logic [SHARES-1:0][7:0] q
);

  localparam int ZM = ZW / 4;

  typedef logic [SHARES-1:0][7:0] shr_t;

  // Squaring is linear, so it acts share-wise.
  function automatic shr_t sq(input shr_t a);
    shr_t r;
    for (int i = 0; i < SHARES; i++) r[i] = gf_mul(a[i], a[i]);
    return r;
  endfunction

  // DOM multiply: cross-domain products are remasked with one fresh byte per share pair.
  function automatic shr_t dom_mul(input shr_t a, input shr_t c, input logic [ZM-1:0] r);
    shr_t y;
    int   p;
    p = 0;
    for (int i = 0; i < SHARES; i++) y[i] = gf_mul(a[i], c[i]);
    for (int i = 0; i < SHARES; i++) begin
      for (int j = i + 1; j < SHARES; j++) begin
        y[i] ^= gf_mul(a[i], c[j]) ^ r[p*8 +: 8];
        y[j] ^= gf_mul(a[j], c[i]) ^ r[p*8 +: 8];
        p++;
      end
    end
    return y;
  endfunction

  // Affine map per share, constant on share 0, then a fresh blinding of the output sharing.
  function automatic shr_t aff_blind(input shr_t a, input logic [BW-1:0] bb);
    shr_t y;
    for (int i = 0; i < SHARES; i++) y[i] = affine_lin(a[i]);
    y[0] ^= AFFINE_C;
    for (int i = 1; i < SHARES; i++) begin
      y[i] ^= bb[(i-1)*8 +: 8];
      y[0] ^= bb[(i-1)*8 +: 8];
    end
    return y;
  endfunction

  shr_t x3_1, x2_1, x15_2, x12_2, x2_2, x252_3, x2_3, inv_4;
  shr_t dly [0:SBOX_LATENCY-5];

  // Free-running datapath: no enable, no reset, each stage consumes its own randomness slice.
  always_ff @(posedge clk) begin
    x3_1   <= dom_mul(sq(x), x, z[0*ZM +: ZM]);
    x2_1   <= sq(x);
    x15_2  <= dom_mul(sq(sq(x3_1)), x3_1, z[1*ZM +: ZM]);
    x12_2  <= sq(sq(x3_1));
    x2_2   <= x2_1;
    x252_3 <= dom_mul(sq(sq(sq(sq(x15_2)))), x12_2, z[2*ZM +: ZM]);
    x2_3   <= x2_2;
    inv_4  <= dom_mul(x252_3, x2_3, z[3*ZM +: ZM]);
    dly[0] <= aff_blind(inv_4, b);
    for (int i = 1; i <= SBOX_LATENCY - 5; i++) dly[i] <= dly[i-1];
  end

  assign q = dly[SBOX_LATENCY-5];

endmodule

// File: rtl/sbox_valid_pipe.sv
// Valid bit plus group index shift register tracking data through the S-box cores.
module sbox_valid_pipe #(
  parameter int DEPTH = 5,
  parameter int GW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [GW-1:0] in_grp,
  output logic          out_vld,
  output logic [GW-1:0] out_grp,
  output logic          occ
);

  logic [DEPTH:1]         vld_pipe;
  logic [DEPTH:1][GW-1:0] grp_pipe;

  // Shift valid/group one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      grp_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      grp_pipe[1] <= in_grp;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        grp_pipe[i] <= grp_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH];
  assign out_grp = grp_pipe[DEPTH];
  assign occ     = |vld_pipe;

endmodule

// File: rtl/aes_sbox_dom_array.sv
// Masked SubBytes engine: streams NUM_BYTES shared bytes through LANES DOM S-box cores.
module aes_sbox_dom_array
  import aes_sbox_dom_pkg::*;
#(
  parameter  int SHARES       = 2,
  parameter  int LANES        = 4,
  parameter  int NUM_BYTES    = 16,
  parameter  int SBOX_LATENCY = 5,
  localparam int Z_WIDTH      = z_width(SHARES),
  localparam int B_WIDTH      = b_width(SHARES)
) (
  input  logic                             ClkxCI,
  input  logic                             RstxRI,
  input  logic                             StartxSI,
  input  logic [8*SHARES*NUM_BYTES-1:0]    StatexDI,
  input  logic                             RndValidxSI,
  input  logic [LANES*(Z_WIDTH+B_WIDTH)-1:0] RndxDI,
  output logic                             RndReadyxSO,
  output logic                             BusyxSO,
  output logic                             DonexSO,
  output logic [8*SHARES*NUM_BYTES-1:0]    QxDO,
  output logic                             RndUnderrunxSO
);

  localparam int SW = 8 * SHARES;
  localparam int RW = Z_WIDTH + B_WIDTH;
  localparam int G  = ceil_div(NUM_BYTES, LANES);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  state_t                      state, state_nxt;
  logic [GW-1:0]               grp, out_grp;
  logic [8*SHARES*NUM_BYTES-1:0] buf_q;
  logic                        start_ok, issue, occ, out_vld;
  logic [LANES-1:0][SW-1:0]    lane_in, lane_out;

  assign start_ok    = (state == ST_IDLE) && StartxSI;
  assign issue       = (state == ST_ISSUE) && RndValidxSI;
  assign RndReadyxSO = RndValidxSI && ((state == ST_ISSUE) || occ);
  assign BusyxSO     = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign DonexSO     = (state == ST_DONE);

  // FSM state register
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: drain ends when the last group leaves the pipe
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (StartxSI) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue && grp == G_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_vld && out_grp == G_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Group counter and sticky randomness-underrun alarm
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      grp            <= '0;
      RndUnderrunxSO <= 1'b0;
    end else begin
      if (start_ok)   grp <= '0;
      else if (issue) grp <= (grp == G_LAST) ? '0 : grp + 1'b1;
      if (start_ok)               RndUnderrunxSO <= 1'b0;
      else if (occ && !RndValidxSI) RndUnderrunxSO <= 1'b1;
    end
  end

  // Input buffer, loaded on start acceptance
  always_ff @(posedge ClkxCI) begin
    if (start_ok) buf_q <= StatexDI;
  end

  // Lane operand select; lanes past NUM_BYTES in the last group see zero shares
  always_comb begin
    lane_in = '0;
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < G; k++)
        if (k * LANES + l < NUM_BYTES && grp == GW'(k))
          lane_in[l] = buf_q[share_lsb(k * LANES + l, 0, SHARES) +: SW];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_dom_core #(
      .SHARES       (SHARES),
      .SBOX_LATENCY (SBOX_LATENCY)
    ) u_core (
      .clk (ClkxCI),
      .x   (lane_in[l]),
      .z   (RndxDI[l*RW +: Z_WIDTH]),
      .b   (RndxDI[l*RW + Z_WIDTH +: B_WIDTH]),
      .q   (lane_out[l])
    );
  end

  sbox_valid_pipe #(
    .DEPTH (SBOX_LATENCY),
    .GW    (GW)
  ) u_vld (
    .clk     (ClkxCI),
    .rst     (RstxRI),
    .in_vld  (issue),
    .in_grp  (grp),
    .out_vld (out_vld),
    .out_grp (out_grp),
    .occ     (occ)
  );

  // Result capture into the byte slots of the group leaving the pipe
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) QxDO <= '0;
    else if (out_vld)
      for (int b = 0; b < NUM_BYTES; b++)
        if (out_grp == GW'(b / LANES))
          QxDO[share_lsb(b, 0, SHARES) +: SW] <= lane_out[b % LANES];
  end

endmodule

// File: tb/tb_aes_sbox_dom_array.sv
// Bench for the masked SubBytes array: default config plus a 3-share, 3-lane config.
module tb_aes_sbox_dom_array;

  logic clk, rst;
  int   n_chk, n_err;

  // Config A: SHARES=2 LANES=4
  logic         start_a, rv_a, rr_a, busy_a, done_a, ur_a;
  logic [255:0] state_a, q_a;
  logic [159:0] rnd_a;
  // Config B: SHARES=3 LANES=3
  logic         start_b, rv_b, rr_b, busy_b, done_b, ur_b;
  logic [383:0] state_b, q_b;
  logic [335:0] rnd_b;

  logic [7:0] exp_q [$];

  aes_sbox_dom_array #(.SHARES(2), .LANES(4), .NUM_BYTES(16), .SBOX_LATENCY(5)) u_dut_a (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start_a), .StatexDI(state_a),
    .RndValidxSI(rv_a), .RndxDI(rnd_a), .RndReadyxSO(rr_a), .BusyxSO(busy_a),
    .DonexSO(done_a), .QxDO(q_a), .RndUnderrunxSO(ur_a));

  aes_sbox_dom_array #(.SHARES(3), .LANES(3), .NUM_BYTES(16), .SBOX_LATENCY(5)) u_dut_b (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start_b), .StatexDI(state_b),
    .RndValidxSI(rv_b), .RndxDI(rnd_b), .RndReadyxSO(rr_b), .BusyxSO(busy_b),
    .DonexSO(done_b), .QxDO(q_b), .RndUnderrunxSO(ur_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fresh randomness every cycle
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 160; i++) rnd_a[i] = 1'($urandom);
    for (int i = 0; i < 336; i++) rnd_b[i] = 1'($urandom);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  // Reference S-box: brute-force inverse then bitwise affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = '0;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  // One operation on config A; rst_cyc>0 aborts with a reset in that cycle
  task automatic run_a(input logic [7:0] pt [16], input int bubbles, input int ur_cyc,
                       input int rst_cyc, input int exp_done, input string tag);
    logic [7:0] m;
    int done_at;
    @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      m = 8'($urandom);
      state_a[b*16 +: 8]     = pt[b] ^ m;
      state_a[b*16 + 8 +: 8] = m;
      exp_q.push_back(sbox_ref(pt[b]));
    end
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 60 && done_at == 0; c++) begin
      rv_a = !(c <= bubbles || c == ur_cyc);
      #1;
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk({tag, "_rst_q"}, int'(q_a == '0), 1);
        chk({tag, "_rst_busy"}, int'(busy_a), 0);
        chk({tag, "_rst_done"}, int'(done_a), 0);
        @(negedge clk);
        rst = 1'b0;
        rv_a = 1'b1;
        exp_q.delete();
        return;
      end
      if (c == 1) begin
        chk({tag, "_busy"}, int'(busy_a), 1);
        chk({tag, "_ur_clr"}, int'(ur_a), 0);
        chk({tag, "_rdy"}, int'(rr_a), int'(rv_a));
      end
      if (done_a) done_at = c;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk({tag, "_done_cyc"}, done_at, exp_done);
    chk({tag, "_busy_done"}, int'(busy_a), 0);
    for (int b = 0; b < 16; b++)
      chk($sformatf("%s_b%0d", tag, b), int'(q_a[b*16 +: 8] ^ q_a[b*16 + 8 +: 8]),
          int'(exp_q.pop_front()));
    rv_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(done_a), 0);
  endtask

  // One operation on config B (three shares, six groups)
  task automatic run_b(input logic [7:0] pt [16], input string tag);
    logic [7:0] m1, m2;
    int done_at;
    @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      m1 = 8'($urandom);
      m2 = 8'($urandom);
      state_b[b*24 +: 8]      = pt[b] ^ m1 ^ m2;
      state_b[b*24 + 8 +: 8]  = m1;
      state_b[b*24 + 16 +: 8] = m2;
      exp_q.push_back(sbox_ref(pt[b]));
    end
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 60 && done_at == 0; c++) begin
      if (done_b) done_at = c;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk({tag, "_done_cyc"}, done_at, 12);
    chk({tag, "_ur"}, int'(ur_b), 0);
    for (int b = 0; b < 16; b++)
      chk($sformatf("%s_b%0d", tag, b),
          int'(q_b[b*24 +: 8] ^ q_b[b*24 + 8 +: 8] ^ q_b[b*24 + 16 +: 8]),
          int'(exp_q.pop_front()));
  endtask

  initial begin
    logic [7:0]   pt [16];
    logic [7:0]   row0 [16];
    logic [255:0] q1;
    n_chk = 0;
    n_err = 0;
    row0 = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
             8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
    rst = 1'b1;
    start_a = 1'b0; rv_a = 1'b1; state_a = '0;
    start_b = 1'b0; rv_b = 1'b1; state_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_q_a", int'(q_a == '0), 1);
    chk("rst_q_b", int'(q_b == '0), 1);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_rdy", int'(rr_a), 0);
    chk("rst_ur", int'(ur_a), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", int'(rr_a), 0);

    // All-zero bytes
    for (int b = 0; b < 16; b++) pt[b] = 8'h00;
    run_a(pt, 0, 0, 0, 10, "zero");
    chk("zero_ur", int'(ur_a), 0);

    // Bytes 0x00..0x0F twice, compared with the known S-box row
    for (int b = 0; b < 16; b++) pt[b] = 8'(b);
    run_a(pt, 0, 0, 0, 10, "seq1");
    q1 = q_a;
    run_a(pt, 0, 0, 0, 10, "seq2");
    for (int b = 0; b < 16; b++)
      chk($sformatf("row0_b%0d", b), int'(q_a[b*16 +: 8] ^ q_a[b*16 + 8 +: 8]), int'(row0[b]));
    chk("shares_differ", int'(q1 != q_a), 1);

    // Three bubbles before the first issue, no underrun
    for (int b = 0; b < 16; b++) pt[b] = 8'($urandom);
    pt[5] = 8'h53;
    run_a(pt, 3, 0, 0, 13, "bub");
    chk("bub_ur", int'(ur_a), 0);
    chk("bub_53", int'(q_a[5*16 +: 8] ^ q_a[5*16 + 8 +: 8]), 8'hed);

    // Randomness gap while data is in flight
    for (int b = 0; b < 16; b++) pt[b] = 8'($urandom);
    run_a(pt, 0, 3, 0, 11, "under");
    chk("under_sticky", int'(ur_a), 1);

    // Reset in DRAIN, then a clean run (also shows start clears the alarm)
    run_a(pt, 0, 0, 7, 10, "abort");
    chk("abort_ur", int'(ur_a), 0);
    for (int b = 0; b < 16; b++) pt[b] = 8'($urandom);
    run_a(pt, 0, 0, 0, 10, "after");

    // Three shares, three lanes, partial last group
    for (int b = 0; b < 16; b++) pt[b] = 8'(b);
    run_b(pt, "b3seq");
    for (int b = 0; b < 16; b++) pt[b] = 8'($urandom);
    run_b(pt, "b3rnd");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
